im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot-time instruction-memory writer for the multi-cycle MIPS core.
- Receives a byte stream (count header followed by instruction words) and writes the words into instruction memory starting at word address 0.
- Holds the CPU in reset until the load completes, then releases it.
- Replaces the simulation-only file preload of instruction memory with a synthesizable path.

Parameters:
ADDR_W, 10, instruction-memory word-address width; DEPTH = 2**ADDR_W words
CNT_W, 16, width of the word-count header

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
im_we  out  1  instruction-memory write strobe, one cycle per word
im_addr  out  ADDR_W  word address for im_we
im_wdata  out  32  instruction word for im_we
cpu_rst  out  1  active-high reset to the MIPS core
done  out  1  load complete, sticky
err  out  1  load failed, sticky

Behaviour:
- Byte transfer: a byte is accepted on a cycle where in_valid && in_ready. in_valid without in_ready has no effect.
- Reset (rst = 0 at a clock edge):
  - state = HDR0, word count = 0, byte index = 0, address counter = 0.
  - im_we = 0, im_addr = 0, im_wdata = 0, cpu_rst = 1, done = 0, err = 0.
- in_ready = rst && state ∈ {HDR0, HDR1, DATA}. It is combinational and goes high in the first cycle after reset release.
- Stream format is big-endian throughout:
  - 2 count bytes, high byte first, giving N.
  - N words of 4 bytes each; the first byte goes to bits [31:24].
- State machine:
  - HDR0: accept byte → cnt[15:8]; go to HDR1.
  - HDR1: accept byte → cnt[7:0], then decide using {cnt_hi, byte}:
    - N == 0 → DONE.
    - N > DEPTH → ERR.
    - otherwise → DATA.
  - DATA: shift accepted bytes into a 32-bit assembly register; byte index 0..3 wraps.
    - On acceptance of byte index 3, the next cycle has im_we = 1, im_addr = address counter, im_wdata = assembled word. The address counter then increments.
    - Input is not stalled during the write cycle; the next byte may be accepted in that same cycle.
    - After word N-1 is accepted, go to DONE, or to CHK if CRC_CHK_EN is compiled in.
  - DONE: done = 1, cpu_rst = 0, in_ready = 0. Remains here until reset; extra input bytes are ignored.
  - ERR: err = 1, cpu_rst = 1, in_ready = 0. Sticky until reset.
- Latency: the write strobe occurs exactly 1 cycle after the 4th byte is accepted. cpu_rst falls in the cycle following the last word's write strobe.
- Boundaries:
  - N == DEPTH is legal; the address counter writes word DEPTH-1 last and never wraps.
  - A stalled stream (in_valid low) holds all state indefinitely.
  - Reset mid-load aborts the load and restarts from HDR0 at address 0. Words already written stay in memory. cpu_rst returns to 1.
- done and err are never both 1.

Optional Feature:
- Macro: CRC_CHK_EN.
- Defined:
  - A running XOR of all N data words is kept.
  - After the last data word the FSM enters CHK and accepts 4 more bytes, big-endian, as the expected checksum.
  - Match → DONE; mismatch → ERR.
  - The checksum word is not written to memory.
- Undefined: the CHK state and XOR register are absent; DATA goes directly to DONE.

Decomposition:
- Shared header loader_defs.v holds:
  - state encodings: HDR0, HDR1, DATA, CHK, DONE, ERR (3-bit);
  - byte-index width;
  - the CRC_CHK_EN guard.
- One sub-module is natural: byte_assembler, a 4-byte big-endian shift register with byte index and a word_valid pulse.
- im_loader instantiates byte_assembler and contains the FSM, counters and output registers.

Test Plan:
- Header 0x00 0x02, bytes 34 08 00 05 20 09 FF FF → im_we pulses twice: addr 0 / 0x34080005, then addr 1 / 0x2009FFFF. Next cycle cpu_rst = 0 and done = 1.
- Header 0x00 0x00 → DONE immediately after the 2nd byte, no im_we pulse, cpu_rst = 0.
- Header 0x04 0x01 (1025 > 1024) → err = 1, in_ready = 0, cpu_rst stays 1, no writes.
- Valid held low for 20 cycles between bytes 2 and 3 of word 0 → the same word 0x34080005 is written; no spurious im_we.
- rst = 0 asserted after 5 bytes of a 3-word load, then a fresh 1-word load of 0x00000000 → write to addr 0, done = 1, outputs reset correctly during rst = 0.
- CRC_CHK_EN defined, words 0x0000FFFF and 0xFFFF0000, checksum 0xFFFFFFFF → done = 1. Same load with checksum 0x00000000 → err = 1, cpu_rst stays 1.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encodings,
// byte-index width and the big-endian byte shift helper.
// The optional checksum stage is compiled in with CRC_CHK_EN.
package im_loader_pkg;

  localparam int BIDX_W = 2;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // Append one byte at the low end; earlier bytes move toward the MSB.
  function automatic logic [31:0] be_shift(input logic [31:0] w, input logic [7:0] b);
    return {w[23:0], b};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master: boot source / memory side. slave: the loader.
interface im_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader_byte_assembler.sv
// Four-byte big-endian word assembler. word_next is the word including the
// byte offered this cycle; word_valid marks the byte that completes a word.
module im_loader_byte_assembler
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_valid
);

  logic [31:0]       word_q, word_d;
  logic [BIDX_W-1:0] idx_q, idx_d;

  assign word_next  = be_shift(word_q, byte_in);
  assign word_valid = byte_en && (idx_q == BIDX_W'(3));

  // Shift in accepted bytes; the index wraps naturally after the 4th byte.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (byte_en) begin
      word_d = word_next;
      idx_d  = idx_q + BIDX_W'(1);
    end
  end

  // Registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader. Parses a big-endian stream of a 16-bit
// word count followed by that many 32-bit words, writes them from address 0
// and then releases the core from reset. Define CRC_CHK_EN to require a
// trailing XOR checksum word before release.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  im_loader_if.slave  bus,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CRC_CHK_EN
  logic [31:0]       xor_q, xor_d;
`endif

  logic              in_ready_w;
  logic              acc;
  logic              asm_en;
  logic [31:0]       word_next;
  logic              word_valid;
  logic [CNT_W-1:0]  hdr_n;
  logic [CNT_W-1:0]  words_plus;

  assign in_ready_w = rst && (state_q == S_HDR0 || state_q == S_HDR1 ||
                              state_q == S_DATA || state_q == S_CHK);
  assign acc        = bus.in_valid && in_ready_w;
  assign asm_en     = acc && (state_q == S_DATA || state_q == S_CHK);
  assign hdr_n      = CNT_W'({cnt_q[7:0], bus.in_data});
  assign words_plus = words_q + CNT_W'(1);

  im_loader_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (asm_en),
    .byte_in    (bus.in_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  // Next-state logic. done/err/cpu_rst follow the state one cycle later so
  // the core leaves reset only after the final write strobe has retired.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_ERR);
    cpu_rst_d  = (state_q != S_DONE);
`ifdef CRC_CHK_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      S_HDR0: begin
        if (acc) begin
          cnt_d   = CNT_W'(bus.in_data);
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (acc) begin
          cnt_d = hdr_n;
          if (hdr_n == '0)              state_d = S_DONE;
          else if (32'(hdr_n) > DEPTH)  state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_valid) begin
          im_we_d    = 1'b1;
          im_addr_d  = words_q[ADDR_W-1:0];
          im_wdata_d = word_next;
          words_d    = words_plus;
`ifdef CRC_CHK_EN
          xor_d      = xor_q ^ word_next;
          if (words_plus == cnt_q) state_d = S_CHK;
`else
          if (words_plus == cnt_q) state_d = S_DONE;
`endif
        end
      end
`ifdef CRC_CHK_EN
      S_CHK: begin
        if (word_valid) state_d = (word_next == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // All state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_HDR0;
      cnt_q      <= '0;
      words_q    <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CRC_CHK_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef CRC_CHK_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: expected memory writes are queued when each word
// is sent; a monitor pops and compares on every im_we strobe.
module tb_im_loader;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rst, done, err;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];
  logic [31:0] xor_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe against the head of the queue.
  initial begin
    logic [41:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got addr %0d data %h expected no write",
                   bus.im_addr, bus.im_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.im_addr), 32'(e[41:32]));
          chk("wr_data", bus.im_wdata, e[31:0]);
        end
      end
    end
  end

  // Drive at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int g;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load(input logic [15:0] n);
    xor_acc = '0;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    xor_acc ^= w;
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic send_chk(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic finish_load();
`ifdef CRC_CHK_EN
    send_chk(xor_acc);
`endif
  endtask

  // Called at the negedge right after the final byte was accepted.
  task automatic check_end(input logic exp_done, input logic exp_err);
    bus.in_valid = 1'b0;
    chk("end_done_pending", 32'(done), 32'd0);
    chk("end_cpu_rst_pending", 32'(cpu_rst), 32'd1);
    chk("end_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_cpu_rst", 32'(cpu_rst), 32'(!exp_done));
    chk("end_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_im_wdata", bus.im_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    xor_acc      = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Two-word load
    start_load(16'h0002);
    send_word(10'd0, 32'h34080005);
    chk("we_latency", 32'(bus.im_we), 32'd1);
    send_word(10'd1, 32'h2009FFFF);
    finish_load();
    check_end(1'b1, 1'b0);
    // Extra bytes in DONE are ignored
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("done_ignore_ready", 32'(bus.in_ready), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);
    idle(1);

    // Empty load
    do_reset();
    start_load(16'h0000);
    check_end(1'b1, 1'b0);

    // Oversized count 1025
    do_reset();
    start_load(16'h0401);
    check_end(1'b0, 1'b1);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_done", 32'(done), 32'd0);
    chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
    idle(1);

    // Stall between bytes 2 and 3 of word 0
    do_reset();
    start_load(16'h0001);
    exp_q.push_back({10'd0, 32'h34080005});
    xor_acc ^= 32'h34080005;
    send_byte(8'h34);
    send_byte(8'h08);
    idle(20);
    chk("stall_cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h00);
    send_byte(8'h05);
    finish_load();
    check_end(1'b1, 1'b0);

    // Reset mid-load after 5 bytes of a 3-word load, then a 1-word load
    do_reset();
    start_load(16'h0003);
    send_word(10'd0, 32'h11223344);
    send_byte(8'h55);
    do_reset();
    start_load(16'h0001);
    send_word(10'd0, 32'h00000000);
    finish_load();
    check_end(1'b1, 1'b0);

    // Full-depth load: 1024 words, last address 1023
    do_reset();
    start_load(16'h0400);
    for (int a = 0; a < 1024; a++)
      send_word(10'(a), (32'(a) * 32'h00010003) ^ 32'h5A5A0000);
    finish_load();
    check_end(1'b1, 1'b0);

`ifdef CRC_CHK_EN
    // Checksum match
    do_reset();
    start_load(16'h0002);
    send_word(10'd0, 32'h0000FFFF);
    send_word(10'd1, 32'hFFFF0000);
    send_chk(32'hFFFFFFFF);
    check_end(1'b1, 1'b0);
    // Checksum mismatch
    do_reset();
    start_load(16'h0002);
    send_word(10'd0, 32'h0000FFFF);
    send_word(10'd1, 32'hFFFF0000);
    send_chk(32'h00000000);
    check_end(1'b0, 1'b1);
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
